inst_prefetch_queue: RTL and testbench

Instruction prefetch queue sitting directly upstream of the decode stage of the 16-bit pipelined CPU. It owns the fetch PC and drives the instruction SRAM (sram0) address. It buffers returned instructions, tagged with their PC, in a small FIFO, and hands them to decode over a valid/ready handshake. Branch redirects from execute (BUN, BSA, ISZ skip) flush the queue and restart fetch at the new PC, replacing the countdown-based fetch freeze.

---
 rtl/inst_prefetch_queue_pkg.sv | 23 ++
 rtl/inst_prefetch_queue_if.sv | 31 +++
 rtl/inst_prefetch_queue_fifo.sv | 45 ++++
 rtl/inst_prefetch_queue.sv | 84 ++++++++
 tb/tb_inst_prefetch_queue.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/inst_prefetch_queue_pkg.sv
// Fetch-path types and constants shared by the prefetch queue and the execute-side redirect source.
package inst_prefetch_queue_pkg;

  localparam int ADDR_WIDTH = 16;
  localparam int DATA_WIDTH = 16;

  localparam logic [ADDR_WIDTH-1:0] RESET_PC = 16'h0000;

  // Opcodes whose execution redirects fetch
  localparam logic [2:0] BUN = 3'b100;
  localparam logic [2:0] BSA = 3'b101;
  localparam logic [2:0] ISZ = 3'b110;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] inst;
  } fetch_entry_t;

  function automatic logic is_redirect_op(input logic [2:0] op);
    return (op == BUN) || (op == BSA) || (op == ISZ);
  endfunction

endpackage

// File: rtl/inst_prefetch_queue_if.sv
// Fetch-side bundle: redirect input, SRAM address/data, and the decode valid/ready handoff.
interface inst_prefetch_queue_if
  import inst_prefetch_queue_pkg::*;
#(
  parameter int ADDR_W = ADDR_WIDTH,
  parameter int DATA_W = DATA_WIDTH,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic [ADDR_W-1:0] addr_0;
  logic [DATA_W-1:0] inst_in;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_inst;
  logic [ADDR_W-1:0] out_pc;
  logic [CNT_W-1:0]  count;

  modport slave (
    input  redirect_valid, redirect_pc, inst_in, out_ready,
    output addr_0, out_valid, out_inst, out_pc, count
  );

  modport master (
    output redirect_valid, redirect_pc, inst_in, out_ready,
    input  addr_0, out_valid, out_inst, out_pc, count
  );

endinterface

// File: rtl/inst_prefetch_queue_fifo.sv
// Synchronous FIFO of tagged fetch entries; flush beats push/pop and keeps the head slot stable.
module prefetch_fifo
  import inst_prefetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);

  fetch_entry_t   mem [DEPTH];
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  wr_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      // Leave rd_ptr alone so the (don't-care) head output does not glitch
      wr_ptr <= rd_ptr;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + (PW+1)'(1);
      else if (!push && pop) count <= count - (PW+1)'(1);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: owns the fetch PC, drives SRAM address, buffers {pc,inst} for decode.
// Optional same-cycle head bypass from the SRAM return path: INST_PREFETCH_BYPASS_EN.
module inst_prefetch_queue
  import inst_prefetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  inst_prefetch_queue_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [ADDR_WIDTH-1:0] fpc;
  logic [ADDR_WIDTH-1:0] inflight_pc;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  inflight;

  fetch_entry_t          head;
  fetch_entry_t          push_data;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_empty;
  logic                  issue;
  logic                  push;
  logic                  pop;
  logic                  bypass_take;

  assign fifo_empty = (fifo_count == '0);

  // Credit counts the in-flight response so a capture can never overflow the FIFO
  assign issue = !bus.redirect_valid && ((fifo_count + CW'(inflight)) < CW'(DEPTH));

`ifdef INST_PREFETCH_BYPASS_EN
  logic bypass_hit;
  assign bypass_hit    = fifo_empty && inflight && !bus.redirect_valid && !reset;
  assign bypass_take   = bypass_hit && bus.out_ready;
  assign bus.out_valid = !fifo_empty || bypass_hit;
  assign bus.out_inst  = bypass_hit ? bus.inst_in : head.inst;
  assign bus.out_pc    = bypass_hit ? inflight_pc : head.pc;
`else
  assign bypass_take   = 1'b0;
  assign bus.out_valid = !fifo_empty;
  assign bus.out_inst  = head.inst;
  assign bus.out_pc    = head.pc;
`endif

  assign pop       = bus.out_valid && bus.out_ready && !fifo_empty;
  assign push      = inflight && !bus.redirect_valid && !bypass_take;
  assign push_data = '{pc: inflight_pc, inst: bus.inst_in};

  prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (bus.redirect_valid),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      fpc         <= RESET_PC;
      addr_q      <= RESET_PC;
      inflight_pc <= RESET_PC;
      inflight    <= 1'b0;
    end else if (bus.redirect_valid) begin
      fpc      <= bus.redirect_pc;
      inflight <= 1'b0;
    end else if (issue) begin
      addr_q      <= fpc;
      inflight_pc <= fpc;
      inflight    <= 1'b1;
      fpc         <= fpc + ADDR_WIDTH'(1);
    end else begin
      inflight <= 1'b0;
    end
  end

  assign bus.addr_0 = addr_q;
  assign bus.count  = fifo_count;

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Directed bench for inst_prefetch_queue with a queue-based reference model checked every cycle.
module tb_inst_prefetch_queue;
  import inst_prefetch_queue_pkg::*;

`ifdef INST_PREFETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  inst_prefetch_queue_if bus ();

  inst_prefetch_queue dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // SRAM model: data for the registered address is present the following cycle
  assign bus.inst_in = bus.addr_0 ^ 16'hA000;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  logic [15:0] mq[$];
  bit          m_inf = 1'b0;
  logic [15:0] m_inf_pc = '0;
  logic [15:0] m_fpc = '0;
  logic [15:0] m_addr = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Compare against the model, then advance the model by what the coming edge must do
  task automatic model_cycle();
    bit          byp_hit;
    bit          mv;
    logic [15:0] mpc;
    int          occ;
    byp_hit = BYP && (mq.size() == 0) && m_inf && !bus.redirect_valid && !reset;
    mv      = (mq.size() > 0) || byp_hit;
    mpc     = (mq.size() > 0) ? mq[0] : m_inf_pc;
    if (chk_en) begin
      chk("model_valid", 32'(bus.out_valid), 32'(mv));
      chk("model_count", 32'(bus.count), 32'(mq.size()));
      chk("model_addr0", 32'(bus.addr_0), 32'(m_addr));
      if (mv) begin
        chk("model_pc", 32'(bus.out_pc), 32'(mpc));
        chk("model_inst", 32'(bus.out_inst), 32'(mpc ^ 16'hA000));
      end
    end
    if (reset) begin
      mq.delete();
      m_inf  = 1'b0;
      m_fpc  = 16'h0000;
      m_addr = 16'h0000;
    end else if (bus.redirect_valid) begin
      mq.delete();
      m_inf = 1'b0;
      m_fpc = bus.redirect_pc;
    end else begin
      occ = mq.size() + int'(m_inf);
      if (mv && bus.out_ready && mq.size() > 0) void'(mq.pop_front());
      if (m_inf && !(byp_hit && bus.out_ready)) mq.push_back(m_inf_pc);
      if (occ < 4) begin
        m_addr   = m_fpc;
        m_inf_pc = m_fpc;
        m_inf    = 1'b1;
        m_fpc    = m_fpc + 16'h0001;
      end else begin
        m_inf = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Check the first n accepted entries form pcs start, start+1, ... (bounded wait)
  task automatic collect(input int n, input logic [15:0] start, input string name);
    int          got;
    logic [15:0] e;
    got = 0;
    for (int c = 0; c < 40 && got < n; c++) begin
      if (bus.out_valid && bus.out_ready) begin
        e = start + 16'(got);
        chk(name, 32'(bus.out_pc), 32'(e));
        got++;
      end
      step();
    end
    if (got < n) begin
      total++;
      bad++;
      $display("FAIL %s_timeout actual=%0d required=%0d", name, got, n);
    end
  endtask

  task automatic do_reset(input logic rdy);
    reset              = 1'b1;
    bus.out_ready      = rdy;
    bus.redirect_valid = 1'b0;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset              = 1'b1;
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    step();
    chk_en = 1'b1;
    chk("reset_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_count", 32'(bus.count), 32'd0);
    chk("reset_addr0", 32'(bus.addr_0), 32'd0);
    chk("reset_pc", 32'(bus.out_pc), 32'd0);
    chk("reset_inst", 32'(bus.out_inst), 32'd0);

    // Reset fill with decode stalled
    do_reset(1'b0);
    step();
    chk("fill_r1_valid", 32'(bus.out_valid), 32'(BYP));
    chk("fill_r1_addr0", 32'(bus.addr_0), 32'h0000);
    step();
    chk("fill_r2_valid", 32'(bus.out_valid), 32'd1);
    chk("fill_r2_pc", 32'(bus.out_pc), 32'h0000);
    steps(3);
    chk("fill_count", 32'(bus.count), 32'd4);
    chk("fill_addr0", 32'(bus.addr_0), 32'h0003);
    steps(2);
    chk("fill_hold_count", 32'(bus.count), 32'd4);
    chk("fill_hold_addr0", 32'(bus.addr_0), 32'h0003);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", 32'(bus.out_valid), 32'd1);
      chk("drain_pc", 32'(bus.out_pc), 32'(i));
      chk("drain_inst", 32'(bus.out_inst), 32'(16'hA000 + 16'(i)));
      step();
    end

    // Throughput: continuous ready from reset
    do_reset(1'b1);
    steps(2);
    for (int k = 0; k < 20; k++) begin
      chk("thru_valid", 32'(bus.out_valid), 32'd1);
      chk("thru_pc", 32'(bus.out_pc), 32'(k + int'(BYP)));
      step();
    end

    // Redirect with two queued and one in flight
    do_reset(1'b0);
    steps(3);
    chk("redir_pre_count", 32'(bus.count), 32'd2);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 16'h0100;
    step();
    bus.redirect_valid = 1'b0;
    chk("redir_flush_count", 32'(bus.count), 32'd0);
    chk("redir_n1_valid", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b1;
    step();
    chk("redir_n1_addr0", 32'(bus.addr_0), 32'h0100);
    collect(2, 16'h0100, "redir_pc");

    // Redirect on an edge that also pops and captures
    steps(3);
    chk("coinc_pre_valid", 32'(bus.out_valid), 32'd1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 16'h0040;
    step();
    bus.redirect_valid = 1'b0;
    chk("coinc_count", 32'(bus.count), 32'd0);
    collect(1, 16'h0040, "coinc_pc");

    // Fetch PC wraps modulo 2^16
    steps(2);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 16'hFFFE;
    step();
    bus.redirect_valid = 1'b0;
    collect(4, 16'hFFFE, "wrap_pc");

    // Reset in the middle of a partial fill
    do_reset(1'b0);
    steps(4);
    chk("mid_pre_count", 32'(bus.count), 32'd3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_count", 32'(bus.count), 32'd0);
    chk("mid_addr0", 32'(bus.addr_0), 32'h0000);
    step();
    chk("mid_r1_valid", 32'(bus.out_valid), 32'(BYP));
    step();
    chk("mid_r2_valid", 32'(bus.out_valid), 32'd1);
    chk("mid_r2_pc", 32'(bus.out_pc), 32'h0000);
    steps(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
